// File: rtl/an_sched_pkg.sv
// Shared definitions for the AN correction scheduler.
//   DEF_ROWS/DEF_COLS/DEF_MSG_W : default array geometry and message width
//   idx_w()                     : index width needed to address n cells
//   state_t                     : scheduler FSM states
package an_sched_pkg;

  localparam int DEF_ROWS  = 6;
  localparam int DEF_COLS  = 6;
  localparam int DEF_MSG_W = 3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/an_sched_lsb_enc.sv
// Lowest-set-bit priority encoder (bit 0 has highest priority).
//   i_vec : candidate vector
//   o_any : at least one bit of i_vec is set
//   o_idx : index of the lowest set bit (0 when o_any is low)
module an_sched_lsb_enc
  import an_sched_pkg::*;
#(
  parameter int N     = 36,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     i_vec,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_any = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/an_corr_scheduler.sv
// Time-shares one AN correction decoder across a ROWS x COLS array of
// residue decoders. A frame of per-cell error flags becomes a candidate
// mask; candidates are issued lowest index first, one write-back per
// corrected cell, up to MAX_CORR per frame.
//   clk, rst             : clock, synchronous active-high reset
//   frm_valid/frm_ready  : frame handshake, frm_err = per-cell flags (r*COLS+c)
//   dec_req/dec_idx      : request to shared decoder, held until dec_ack
//   dec_ack/dec_msg      : decoder result
//   wb_valid/wb_idx/wb_msg : registered write-back strobe
//   frm_done/frm_ncorr/frm_ovf : end-of-frame pulse, correction count, overflow
module an_corr_scheduler
  import an_sched_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int MSG_W     = DEF_MSG_W,
  parameter int MAX_CORR  = ROWS * COLS,
  parameter int USE_XSECT = 0,
  localparam int N        = ROWS * COLS,
  localparam int IDX_W    = idx_w(N),
  localparam int CNT_W    = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frm_valid,
  output logic             frm_ready,
  input  logic [N-1:0]     frm_err,
  output logic             dec_req,
  output logic [IDX_W-1:0] dec_idx,
  input  logic             dec_ack,
  input  logic [MSG_W-1:0] dec_msg,
  output logic             wb_valid,
  output logic [IDX_W-1:0] wb_idx,
  output logic [MSG_W-1:0] wb_msg,
  output logic             frm_done,
  output logic [CNT_W-1:0] frm_ncorr,
  output logic             frm_ovf
);

  state_t           r_state;
  state_t           w_next;
  logic [N-1:0]     r_mask;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_dec_idx;
  logic             r_wb_valid;
  logic [IDX_W-1:0] r_wb_idx;
  logic [MSG_W-1:0] r_wb_msg;
  logic [N-1:0]     w_cand;
  logic             w_any;
  logic [IDX_W-1:0] w_lsb_idx;
  logic             w_pick_go;

  // Candidate mask: either the raw flags, or every cell sitting at the
  // crossing of a flagged row and a flagged column.
  if (USE_XSECT != 0) begin : g_xsect
    logic [ROWS-1:0] w_row_any;
    logic [COLS-1:0] w_col_any;
    always_comb begin
      w_row_any = '0;
      w_col_any = '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (frm_err[r*COLS+c]) begin
            w_row_any[r] = 1'b1;
            w_col_any[c] = 1'b1;
          end
        end
      end
      w_cand = '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          w_cand[r*COLS+c] = w_row_any[r] & w_col_any[c];
        end
      end
    end
  end else begin : g_own
    assign w_cand = frm_err;
  end

  an_sched_lsb_enc #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_lsb_enc (
    .i_vec (r_mask),
    .o_any (w_any),
    .o_idx (w_lsb_idx)
  );

  // The count can only reach MAX_CORR, so this stop condition is also
  // what keeps it saturated.
  assign w_pick_go = w_any && (r_cnt != CNT_W'(MAX_CORR));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    frm_ready = 1'b0;
    dec_req   = 1'b0;
    frm_done  = 1'b0;
    case (r_state)
      IDLE: begin
        frm_ready = 1'b1;
        if (frm_valid) w_next = PICK;
      end
      PICK: w_next = w_pick_go ? REQ : DONE;
      REQ: begin
        dec_req = 1'b1;
        if (dec_ack) w_next = PICK;
      end
      DONE: begin
        frm_done = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask     <= '0;
      r_cnt      <= '0;
      r_dec_idx  <= '0;
      r_wb_valid <= 1'b0;
      r_wb_idx   <= '0;
      r_wb_msg   <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (frm_valid) begin
            r_mask <= w_cand;
            r_cnt  <= '0;
          end
        end
        PICK: begin
          if (w_pick_go) r_dec_idx <= w_lsb_idx;
        end
        REQ: begin
          if (dec_ack) begin
            r_mask     <= r_mask & ~(N'(1) << r_dec_idx);
            r_cnt      <= r_cnt + 1'b1;
            r_wb_valid <= 1'b1;
            r_wb_idx   <= r_dec_idx;
            r_wb_msg   <= dec_msg;
          end
        end
        default: ;
      endcase
    end
  end

  assign dec_idx   = r_dec_idx;
  assign wb_valid  = r_wb_valid;
  assign wb_idx    = r_wb_idx;
  assign wb_msg    = r_wb_msg;
  assign frm_ncorr = r_cnt;
  // Leftover candidates at end of frame mean MAX_CORR cut the frame short.
  assign frm_ovf   = frm_done & (|r_mask);

endmodule

// File: tb/tb_an_corr_scheduler.sv
// Bench for an_corr_scheduler: three instances (own-flag mode, intersection
// mode, MAX_CORR=2) driven through directed and randomized frames, compared
// against a list-based reference of which cells should be corrected.
module tb_an_corr_scheduler;

  localparam int N = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           fv   [3];
  logic [N-1:0]   fe   [3];
  logic           ack  [3];
  logic [2:0]     msg  [3];
  logic           rdy  [3];
  logic           req  [3];
  logic           wbv  [3];
  logic           done [3];
  logic           ovf  [3];
  logic [5:0]     didx [3];
  logic [5:0]     wbi  [3];
  logic [2:0]     wbm  [3];
  logic [6:0]     ncorr[3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  an_corr_scheduler #(.ROWS(6), .COLS(6), .MSG_W(3), .MAX_CORR(36), .USE_XSECT(0)) u_own (
    .clk(clk), .rst(rst), .frm_valid(fv[0]), .frm_ready(rdy[0]), .frm_err(fe[0]),
    .dec_req(req[0]), .dec_idx(didx[0]), .dec_ack(ack[0]), .dec_msg(msg[0]),
    .wb_valid(wbv[0]), .wb_idx(wbi[0]), .wb_msg(wbm[0]),
    .frm_done(done[0]), .frm_ncorr(ncorr[0]), .frm_ovf(ovf[0]));

  an_corr_scheduler #(.ROWS(6), .COLS(6), .MSG_W(3), .MAX_CORR(36), .USE_XSECT(1)) u_xs (
    .clk(clk), .rst(rst), .frm_valid(fv[1]), .frm_ready(rdy[1]), .frm_err(fe[1]),
    .dec_req(req[1]), .dec_idx(didx[1]), .dec_ack(ack[1]), .dec_msg(msg[1]),
    .wb_valid(wbv[1]), .wb_idx(wbi[1]), .wb_msg(wbm[1]),
    .frm_done(done[1]), .frm_ncorr(ncorr[1]), .frm_ovf(ovf[1]));

  an_corr_scheduler #(.ROWS(6), .COLS(6), .MSG_W(3), .MAX_CORR(2), .USE_XSECT(0)) u_ovf (
    .clk(clk), .rst(rst), .frm_valid(fv[2]), .frm_ready(rdy[2]), .frm_err(fe[2]),
    .dec_req(req[2]), .dec_idx(didx[2]), .dec_ack(ack[2]), .dec_msg(msg[2]),
    .wb_valid(wbv[2]), .wb_idx(wbi[2]), .wb_msg(wbm[2]),
    .frm_done(done[2]), .frm_ncorr(ncorr[2]), .frm_ovf(ovf[2]));

  // Reference: cells to correct, in issue order, and whether any were left over.
  int exp_q[$];
  bit exp_ovf;

  function automatic void build_exp(input int d, input logic [N-1:0] err);
    bit [5:0] ra;
    bit [5:0] ca;
    bit       cand;
    int       maxc;
    exp_q.delete();
    exp_ovf = 1'b0;
    ra = '0;
    ca = '0;
    maxc = (d == 2) ? 2 : 36;
    for (int i = 0; i < N; i++) if (err[i]) begin ra[i/6] = 1'b1; ca[i%6] = 1'b1; end
    for (int i = 0; i < N; i++) begin
      cand = (d == 1) ? (ra[i/6] & ca[i%6]) : err[i];
      if (cand) begin
        if (exp_q.size() < maxc) exp_q.push_back(i);
        else exp_ovf = 1'b1;
      end
    end
  endfunction

  // Observations collected by run_frame.
  int         obs_req[$];
  int         obs_wb[$];
  int         obs_msg[$];
  int         sent_msg[$];
  int         done_off, wb_last_off, unstable, sum_wait, frame_t0;
  bit         timed_out, not_ready;
  logic [6:0] obs_ncorr;
  logic       obs_ovf;

  // Drives one frame into instance d and records everything it emits.
  // fixed_msg < 0 gives random decoder messages; junk sprays ignored
  // frm_valid/frm_err while busy and stray acks when no request is up.
  task automatic run_frame(input int d, input logic [N-1:0] err, input int mind,
                           input int maxd, input bit junk, input int fixed_msg);
    int         remaining;
    bit         in_req;
    int         m;
    logic [5:0] hold;
    logic [63:0] rnd;
    obs_req.delete(); obs_wb.delete(); obs_msg.delete(); sent_msg.delete();
    done_off = -1; wb_last_off = -1; unstable = 0; sum_wait = 0;
    timed_out = 1'b0; not_ready = 1'b0; obs_ncorr = '0; obs_ovf = 1'b0;
    hold = '0; remaining = 0; in_req = 1'b0;
    @(negedge clk);
    if (rdy[d] !== 1'b1) not_ready = 1'b1;
    fv[d] = 1'b1; fe[d] = err; ack[d] = 1'b0;
    frame_t0 = cyc;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      rnd = {$urandom(), $urandom()};
      fv[d] = junk ? rnd[40] : 1'b0;
      if (junk) fe[d] = rnd[N-1:0];
      if (wbv[d]) begin
        obs_wb.push_back(int'(wbi[d]));
        obs_msg.push_back(int'(wbm[d]));
        wb_last_off = cyc - frame_t0;
      end
      if (done[d]) begin
        done_off = cyc - frame_t0;
        obs_ncorr = ncorr[d];
        obs_ovf = ovf[d];
        fv[d] = 1'b0; ack[d] = 1'b0;
        break;
      end
      if (req[d]) begin
        if (!in_req) begin
          in_req = 1'b1;
          hold = didx[d];
          obs_req.push_back(int'(didx[d]));
          remaining = int'($urandom_range(maxd, mind));
          sum_wait += remaining;
        end else if (didx[d] !== hold) begin
          unstable++;
        end
        if (remaining == 0) begin
          m = (fixed_msg >= 0) ? fixed_msg : int'($urandom_range(7, 0));
          ack[d] = 1'b1; msg[d] = 3'(m);
          sent_msg.push_back(m);
          in_req = 1'b0;
        end else begin
          remaining--;
          ack[d] = 1'b0; msg[d] = rnd[50:48];
        end
      end else begin
        in_req = 1'b0;
        ack[d] = junk ? rnd[45] : 1'b0;
        msg[d] = rnd[50:48];
      end
    end
    if (done_off < 0) timed_out = 1'b1;
    fv[d] = 1'b0; ack[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (req[d] !== 1'b0 || didx[d] !== 6'd0 || wbv[d] !== 1'b0 || wbi[d] !== 6'd0 ||
          wbm[d] !== 3'd0 || done[d] !== 1'b0 || ncorr[d] !== 7'd0 || ovf[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_values[%0d]: req=%b idx=%0d wbv=%b wbi=%0d wbm=%0d done=%b ncorr=%0d ovf=%b, required all 0",
                 d, req[d], didx[d], wbv[d], wbi[d], wbm[d], done[d], ncorr[d], ovf[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rdy[d] !== 1'b1) begin
        failures++;
        $display("FAIL reset_ready[%0d]: got %b required 1", d, rdy[d]);
      end
    end
  endtask

  task automatic test_empty();
    run_frame(0, '0, 0, 0, 1'b0, -1);
    checks++;
    if (timed_out || done_off != 2) begin
      failures++; $display("FAIL empty_done_off: got %0d required 2", done_off);
    end
    checks++;
    if (obs_ncorr !== 7'd0 || obs_ovf !== 1'b0) begin
      failures++; $display("FAIL empty_ncorr_ovf: got %0d/%b required 0/0", obs_ncorr, obs_ovf);
    end
    checks++;
    if (obs_req.size() != 0 || obs_wb.size() != 0) begin
      failures++; $display("FAIL empty_activity: req=%0d wb=%0d required 0/0", obs_req.size(), obs_wb.size());
    end
  endtask

  task automatic test_single();
    logic [N-1:0] e;
    e = '0; e[14] = 1'b1;
    run_frame(0, e, 0, 0, 1'b0, 5);
    checks++;
    if (obs_req.size() != 1 || obs_req[0] != 14) begin
      failures++; $display("FAIL single_dec_idx: got n=%0d first=%0d required n=1 idx=14", obs_req.size(), obs_req[0]);
    end
    checks++;
    if (obs_wb.size() != 1 || obs_wb[0] != 14 || obs_msg[0] != 5) begin
      failures++; $display("FAIL single_wb: got n=%0d idx=%0d msg=%0d required 1/14/5", obs_wb.size(), obs_wb[0], obs_msg[0]);
    end
    checks++;
    if (wb_last_off != 3 || done_off != 4) begin
      failures++; $display("FAIL single_timing: wb at %0d done at %0d required 3/4", wb_last_off, done_off);
    end
    checks++;
    if (obs_ncorr !== 7'd1 || obs_ovf !== 1'b0) begin
      failures++; $display("FAIL single_ncorr: got %0d/%b required 1/0", obs_ncorr, obs_ovf);
    end
  endtask

  task automatic test_multi_delay();
    logic [N-1:0] e;
    int want[$];
    want = '{0, 7, 35};
    e = '0; e[0] = 1'b1; e[7] = 1'b1; e[35] = 1'b1;
    run_frame(0, e, 3, 3, 1'b1, -1);
    checks++;
    if (obs_req.size() != 3 || obs_wb.size() != 3) begin
      failures++; $display("FAIL multi_counts: req=%0d wb=%0d required 3/3", obs_req.size(), obs_wb.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_req[i] != want[i] || obs_wb[i] != want[i] || obs_msg[i] != sent_msg[i]) begin
        failures++;
        $display("FAIL multi_order[%0d]: req=%0d wb=%0d msg=%0d required %0d/%0d/%0d",
                 i, obs_req[i], obs_wb[i], obs_msg[i], want[i], want[i], sent_msg[i]);
      end
    end
    checks++;
    if (unstable != 0) begin
      failures++; $display("FAIL multi_idx_stable: %0d changes while waiting, required 0", unstable);
    end
    checks++;
    if (done_off != 17 || wb_last_off != 16 || obs_ncorr !== 7'd3 || obs_ovf !== 1'b0) begin
      failures++; $display("FAIL multi_done: off=%0d wb=%0d ncorr=%0d ovf=%b required 17/16/3/0",
                           done_off, wb_last_off, obs_ncorr, obs_ovf);
    end
  endtask

  task automatic test_xsect();
    logic [N-1:0] e;
    int want[$];
    want = '{1, 2, 7, 8};
    e = '0; e[1] = 1'b1; e[8] = 1'b1;
    run_frame(1, e, 0, 2, 1'b0, -1);
    checks++;
    if (obs_wb.size() != 4) begin
      failures++; $display("FAIL xsect_count: got %0d required 4", obs_wb.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_req[i] != want[i] || obs_wb[i] != want[i]) begin
        failures++; $display("FAIL xsect_order[%0d]: req=%0d wb=%0d required %0d", i, obs_req[i], obs_wb[i], want[i]);
      end
    end
    checks++;
    if (obs_ncorr !== 7'd4 || done_off != 10 + sum_wait) begin
      failures++; $display("FAIL xsect_done: ncorr=%0d off=%0d required 4/%0d", obs_ncorr, done_off, 10 + sum_wait);
    end
  endtask

  task automatic test_overflow();
    logic [N-1:0] e;
    e = '0; e[3] = 1'b1; e[4] = 1'b1; e[5] = 1'b1;
    run_frame(2, e, 0, 1, 1'b0, -1);
    checks++;
    if (obs_wb.size() != 2 || obs_wb[0] != 3 || obs_wb[1] != 4) begin
      failures++; $display("FAIL ovf_wb: n=%0d first=%0d second=%0d required 2/3/4", obs_wb.size(), obs_wb[0], obs_wb[1]);
    end
    checks++;
    if (obs_ncorr !== 7'd2 || obs_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_flags: ncorr=%0d ovf=%b required 2/1", obs_ncorr, obs_ovf);
    end
    checks++;
    if (done_off != 6 + sum_wait) begin
      failures++; $display("FAIL ovf_done_off: got %0d required %0d", done_off, 6 + sum_wait);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] e;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    e = '0; e[9] = 1'b1;
    fv[0] = 1'b1; fe[0] = e; ack[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      fv[0] = 1'b0;
      if (req[0] === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL rmid_req_seen: got 0 required 1");
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req[0] !== 1'b0) begin
      failures++; $display("FAIL rmid_req_drop: got %b required 0", req[0]);
    end
    rst = 1'b0; ack[0] = 1'b1; msg[0] = 3'd6;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ack[0] = 1'b0;
      checks++;
      if (wbv[0] !== 1'b0 || done[0] !== 1'b0 || rdy[0] !== 1'b1) begin
        failures++; $display("FAIL rmid_quiet[%0d]: wbv=%b done=%b rdy=%b required 0/0/1", k, wbv[0], done[0], rdy[0]);
      end
    end
    e = '0; e[20] = 1'b1;
    run_frame(0, e, 0, 2, 1'b0, -1);
    checks++;
    if (timed_out || obs_wb.size() != 1 || obs_wb[0] != 20 || obs_ncorr !== 7'd1) begin
      failures++; $display("FAIL rmid_next_frame: n=%0d wb=%0d ncorr=%0d required 1/20/1", obs_wb.size(), obs_wb[0], obs_ncorr);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rnd;
    int prev_t0, prev_done;
    prev_t0 = -1; prev_done = 0;
    for (int f = 0; f < 4; f++) begin
      rnd = {$urandom(), $urandom()};
      run_frame(0, rnd[N-1:0] & {$urandom(), 4'hF}, 0, 0, 1'b0, -1);
      build_exp(0, fe[0]);
      if (prev_t0 >= 0) begin
        checks++;
        if (not_ready || frame_t0 != prev_t0 + prev_done + 1) begin
          failures++; $display("FAIL b2b_period[%0d]: t0=%0d required %0d", f, frame_t0, prev_t0 + prev_done + 1);
        end
      end
      checks++;
      if (timed_out || done_off != 2 * exp_q.size() + 2 || obs_wb.size() != exp_q.size()) begin
        failures++; $display("FAIL b2b_frame[%0d]: off=%0d wb=%0d required %0d/%0d",
                             f, done_off, obs_wb.size(), 2 * exp_q.size() + 2, exp_q.size());
      end
      prev_t0 = frame_t0; prev_done = done_off;
    end
  endtask

  task automatic test_random();
    logic [63:0] r1, r2, r3;
    logic [N-1:0] e;
    int d, mode, k;
    for (int f = 0; f < 40; f++) begin
      d = int'($urandom_range(2, 0));
      mode = int'($urandom_range(3, 0));
      r1 = {$urandom(), $urandom()}; r2 = {$urandom(), $urandom()}; r3 = {$urandom(), $urandom()};
      case (mode)
        0: e = '0;
        1: e = r1[N-1:0] & r2[N-1:0] & r3[N-1:0];
        2: e = r1[N-1:0];
        default: begin e = '0; e[$urandom_range(35, 0)] = 1'b1; end
      endcase
      build_exp(d, e);
      k = exp_q.size();
      run_frame(d, e, 0, 3, 1'b1, -1);
      checks++;
      if (timed_out || not_ready) begin
        failures++; $display("FAIL rand_handshake[%0d]: timed_out=%b not_ready=%b required 0/0", f, timed_out, not_ready);
      end
      checks++;
      if (obs_req.size() != k || obs_wb.size() != k || obs_msg.size() != sent_msg.size()) begin
        failures++; $display("FAIL rand_counts[%0d] dut%0d: req=%0d wb=%0d required %0d", f, d, obs_req.size(), obs_wb.size(), k);
      end
      for (int i = 0; i < k; i++) begin
        checks++;
        if (obs_req[i] != exp_q[i] || obs_wb[i] != exp_q[i] || obs_msg[i] != sent_msg[i]) begin
          failures++; $display("FAIL rand_item[%0d.%0d] dut%0d: req=%0d wb=%0d msg=%0d required %0d/%0d/%0d",
                               f, i, d, obs_req[i], obs_wb[i], obs_msg[i], exp_q[i], exp_q[i], sent_msg[i]);
        end
      end
      checks++;
      if (done_off != 2 * k + 2 + sum_wait || (k > 0 && wb_last_off != done_off - 1)) begin
        failures++; $display("FAIL rand_timing[%0d] dut%0d: done=%0d wb_last=%0d required %0d",
                             f, d, done_off, wb_last_off, 2 * k + 2 + sum_wait);
      end
      checks++;
      if (obs_ncorr != 7'(k) || obs_ovf !== exp_ovf || unstable != 0) begin
        failures++; $display("FAIL rand_summary[%0d] dut%0d: ncorr=%0d ovf=%b unstable=%0d required %0d/%b/0",
                             f, d, obs_ncorr, obs_ovf, unstable, k, exp_ovf);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      fv[d] = 1'b0; fe[d] = '0; ack[d] = 1'b0; msg[d] = '0;
    end
    test_reset();
    test_empty();
    test_single();
    test_multi_delay();
    test_xsect();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
